// File: rtl/force_cache_pkg.sv
// rtl/force_cache_pkg.sv - shared widths, FSM encoding and force-entry layout for the force cache reader
package force_cache_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int CELL_ID_WIDTH     = 4;
  localparam int CELL_ADDR_WIDTH   = 9;
  localparam int PARTICLE_ID_WIDTH = CELL_ID_WIDTH * 3 + CELL_ADDR_WIDTH;
  localparam int FORCE_WIDTH       = 3 * DATA_WIDTH;
  localparam int ENTRY_WIDTH       = PARTICLE_ID_WIDTH + FORCE_WIDTH;

  // Captured entry layout, MSB first: {id, Fz, Fy, Fx}
  localparam int FX_LSB = 0;
  localparam int FY_LSB = DATA_WIDTH;
  localparam int FZ_LSB = 2 * DATA_WIDTH;
  localparam int ID_LSB = 3 * DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_READ    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } rd_state_e;

  function automatic logic [ENTRY_WIDTH-1:0] pack_entry(
    input logic [PARTICLE_ID_WIDTH-1:0] id,
    input logic [FORCE_WIDTH-1:0]       force_v
  );
    return {id, force_v};
  endfunction

endpackage

// File: rtl/force_readout_fifo.sv
// rtl/force_readout_fifo.sv - small sync FIFO with a registered head; valid mirrors !empty
module force_readout_fifo
  import force_cache_pkg::*;
#(
  parameter int WIDTH = ENTRY_WIDTH,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    // The incoming word becomes the head when it lands in the slot the read pointer moves to.
    if (level_d == '0) begin
      head_d = head_q;
    end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  assign head_data = head_q;
  assign valid     = !empty;
  assign level     = level_q;

endmodule

// File: rtl/force_cache_readout_controller.sv
// rtl/force_cache_readout_controller.sv - waits for the write pipeline to settle, reads a cell's
// force cache into a credit-protected FIFO and streams the entries to the motion-update stage
module force_cache_readout_controller
  import force_cache_pkg::*;
#(
  parameter int READ_LATENCY    = 2,
  parameter int QUIESCE_CYCLES  = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_start,
  input  logic [CELL_ADDR_WIDTH-1:0]   in_particle_count,
  output logic                         out_read_data_request,
  output logic [CELL_ADDR_WIDTH-1:0]   out_cache_read_address,
  input  logic                         in_cache_readout_valid,
  input  logic [3*DATA_WIDTH-1:0]      in_partial_force,
  input  logic [PARTICLE_ID_WIDTH-1:0] in_particle_id,
  output logic                         out_force_valid,
  input  logic                         in_force_ready,
  output logic [3*DATA_WIDTH-1:0]      out_force,
  output logic [PARTICLE_ID_WIDTH-1:0] out_particle_id,
  output logic                         out_busy,
  output logic                         out_done,
  output logic                         out_overflow_error
);

  localparam int CAW = CELL_ADDR_WIDTH;
  localparam int QCW = $clog2(QUIESCE_CYCLES + 1);
  localparam int CRW = FIFO_ADDR_WIDTH + 1;

  if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_depth_check
    $error("FIFO_DEPTH must cover READ_LATENCY+1 in-flight reads");
  end
  if (FIFO_DEPTH != (1 << FIFO_ADDR_WIDTH)) begin : g_addr_check
    $error("FIFO_DEPTH must equal 2**FIFO_ADDR_WIDTH");
  end

  rd_state_e        state_q, state_d;
  logic [CAW-1:0]   count_q, count_d;
  logic [CAW-1:0]   addr_q, addr_d;
  logic [CAW-1:0]   returned_q, returned_d;
  logic [QCW-1:0]   quiesce_q, quiesce_d;
  logic [CRW-1:0]   credits_q, credits_d;
  logic             overflow_q, overflow_d;

  logic [ENTRY_WIDTH-1:0] fifo_head;
  logic                   fifo_valid, fifo_full, fifo_empty;
  logic [CRW-1:0]         fifo_level;
  logic                   issue, pop, fifo_will_empty;

  force_readout_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_cache_readout_valid),
    .push_data (pack_entry(in_particle_id, in_partial_force)),
    .pop       (pop),
    .head_data (fifo_head),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign issue = (state_q == ST_READ) && (credits_q != '0);
  assign pop   = fifo_valid && in_force_ready;
  // Looking one pop ahead lets done follow the last beat by a single cycle.
  assign fifo_will_empty = fifo_empty ||
                           ((fifo_level == CRW'(1)) && pop && !in_cache_readout_valid);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    returned_d = returned_q;
    quiesce_d  = quiesce_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          count_d    = in_particle_count;
          addr_d     = CAW'(1);
          returned_d = '0;
          quiesce_d  = '0;
          state_d    = (in_particle_count == '0) ? ST_DONE : ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        if (quiesce_q == QCW'(QUIESCE_CYCLES - 1)) begin
          state_d = ST_READ;
        end else begin
          quiesce_d = quiesce_q + QCW'(1);
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d = addr_q + CAW'(1);
          if (addr_q == count_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((returned_q == count_q) && fifo_will_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (((state_q == ST_READ) || (state_q == ST_DRAIN)) && in_cache_readout_valid) begin
      returned_d = returned_q + CAW'(1);
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (issue && !pop) begin
      credits_d = credits_q - CRW'(1);
    end else if (pop && !issue && (credits_q != CRW'(FIFO_DEPTH))) begin
      credits_d = credits_q + CRW'(1);
    end
    overflow_d = overflow_q || (in_cache_readout_valid && fifo_full);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      addr_q     <= CAW'(1);
      returned_q <= '0;
      quiesce_q  <= '0;
      credits_q  <= CRW'(FIFO_DEPTH);
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      returned_q <= returned_d;
      quiesce_q  <= quiesce_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_read_data_request  = issue;
  assign out_cache_read_address = (state_q == ST_READ) ? addr_q : '0;
  assign out_force_valid        = fifo_valid;
  assign out_force              = fifo_head[ID_LSB-1:FX_LSB];
  assign out_particle_id        = fifo_head[ID_LSB +: PARTICLE_ID_WIDTH];
  assign out_busy               = (state_q != ST_IDLE);
  assign out_done               = (state_q == ST_DONE);
  assign out_overflow_error     = overflow_q;

endmodule

// File: tb/tb_force_cache_readout_controller.sv
// tb/tb_force_cache_readout_controller.sv - scoreboard bench with a latency-2 force cache model
module tb_force_cache_readout_controller;
  import force_cache_pkg::*;

  localparam int PIDW = PARTICLE_ID_WIDTH;
  localparam int FW   = 3 * DATA_WIDTH;
  localparam int CAW  = CELL_ADDR_WIDTH;

  logic            clk, rst, in_start;
  logic [CAW-1:0]  in_particle_count;
  logic            out_read_data_request;
  logic [CAW-1:0]  out_cache_read_address;
  logic            in_cache_readout_valid;
  logic [FW-1:0]   in_partial_force;
  logic [PIDW-1:0] in_particle_id;
  logic            out_force_valid, in_force_ready;
  logic [FW-1:0]   out_force;
  logic [PIDW-1:0] out_particle_id;
  logic            out_busy, out_done, out_overflow_error;

  logic                   model_v, s1_v, cap_v;
  logic [ENTRY_WIDTH-1:0] model_d, s1_d, cap_d;
  logic                   inj_valid, inj_drop;
  logic [ENTRY_WIDTH-1:0] inj_data, rd_entry, prev_head;
  logic                   prev_stall;

  int tests_run, tests_failed, cyc, salt, exp_addr;
  int req_cnt, beat_cnt, done_cnt, gap_cnt;
  int first_req_cyc, last_req_cyc, last_beat_cyc, done_cyc, start_cyc;
  logic [ENTRY_WIDTH-1:0] sb [$];

  assign in_cache_readout_valid = model_v | inj_valid;
  assign rd_entry               = inj_valid ? inj_data : model_d;
  assign in_particle_id         = rd_entry[ENTRY_WIDTH-1 -: PIDW];
  assign in_partial_force       = rd_entry[FW-1:0];

  force_cache_readout_controller dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_start               (in_start),
    .in_particle_count      (in_particle_count),
    .out_read_data_request  (out_read_data_request),
    .out_cache_read_address (out_cache_read_address),
    .in_cache_readout_valid (in_cache_readout_valid),
    .in_partial_force       (in_partial_force),
    .in_particle_id         (in_particle_id),
    .out_force_valid        (out_force_valid),
    .in_force_ready         (in_force_ready),
    .out_force              (out_force),
    .out_particle_id        (out_particle_id),
    .out_busy               (out_busy),
    .out_done               (out_done),
    .out_overflow_error     (out_overflow_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [ENTRY_WIDTH-1:0] cache_entry(input int a, input int s);
    logic [PIDW-1:0]       id;
    logic [DATA_WIDTH-1:0] fx, fy, fz;
    id = PIDW'(((s & 'hfff) << 9) | (a & 'h1ff));
    fx = DATA_WIDTH'(a * 65539 + s);
    fy = 32'hC0DE_0000 ^ DATA_WIDTH'(a << 4);
    fz = ~DATA_WIDTH'(a + s * 7);
    return {id, fz, fy, fx};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] want);
    tests_run++;
    if (obs !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  task automatic sb_clear();
    sb.delete();
    exp_addr = 1; req_cnt = 0; beat_cnt = 0; done_cnt = 0; gap_cnt = 0;
    first_req_cyc = 0; last_req_cyc = 0; last_beat_cyc = 0; done_cyc = 0;
  endtask

  task automatic monitor();
    logic [ENTRY_WIDTH-1:0] e;
    if (!rst) begin
      prev_stall = 1'b0;
      cap_v      = 1'b0;
      return;
    end
    if (out_read_data_request) begin
      check_eq("req_addr", 128'(out_cache_read_address), 128'(exp_addr));
      sb.push_back(cache_entry(exp_addr, salt));
      exp_addr++;
      req_cnt++;
      if (req_cnt == 1) first_req_cyc = cyc;
      else if (cyc != last_req_cyc + 1) gap_cnt++;
      last_req_cyc = cyc;
    end
    cap_v = out_read_data_request;
    cap_d = cache_entry(int'(out_cache_read_address), salt);
    if (inj_valid && !inj_drop) sb.push_back(inj_data);
    if (prev_stall) begin
      check_eq("hold_valid", 128'(out_force_valid), 128'(1));
      check_eq("hold_data", 128'({out_particle_id, out_force}), 128'(prev_head));
    end
    if (out_force_valid && in_force_ready) begin
      check_eq("sb_nonempty", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("beat", 128'({out_particle_id, out_force}), 128'(e));
      end
      beat_cnt++;
      last_beat_cyc = cyc;
    end
    prev_stall = out_force_valid && !in_force_ready;
    prev_head  = {out_particle_id, out_force};
    if (out_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (!rst) begin
      model_v = 1'b0; s1_v = 1'b0; cap_v = 1'b0;
    end else begin
      model_v = s1_v; model_d = s1_d;
      s1_v    = cap_v; s1_d   = cap_d;
    end
  endtask

  task automatic start_op(input int n);
    salt++;
    sb_clear();
    in_particle_count = CAW'(n);
    in_start  = 1'b1;
    start_cyc = cyc;
    step();
    in_start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) step();
    check_eq(tag, 128'(done_cnt), 128'(1));
  endtask

  task automatic wait_req(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && req_cnt < n; i++) step();
    check_eq(tag, 128'(req_cnt >= n), 128'(1));
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    sb_clear();
  endtask

  task automatic check_reset_state(input string p);
    check_eq({p, "_req"},   128'(out_read_data_request),  128'(0));
    check_eq({p, "_addr"},  128'(out_cache_read_address), 128'(0));
    check_eq({p, "_valid"}, 128'(out_force_valid),        128'(0));
    check_eq({p, "_busy"},  128'(out_busy),               128'(0));
    check_eq({p, "_done"},  128'(out_done),               128'(0));
    check_eq({p, "_ovf"},   128'(out_overflow_error),     128'(0));
    check_eq({p, "_data"},  128'({out_particle_id, out_force}), 128'(0));
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0; salt = 0;
    rst = 1'b0; in_start = 1'b0; in_particle_count = '0; in_force_ready = 1'b1;
    inj_valid = 1'b0; inj_drop = 1'b0; inj_data = '0;
    model_v = 1'b0; model_d = '0; s1_v = 1'b0; s1_d = '0; cap_v = 1'b0; cap_d = '0;
    prev_stall = 1'b0; prev_head = '0;
    sb_clear();
    step();
    step();
    rst = 1'b1;
    check_reset_state("rst");

    // T1: basic run, free-flowing downstream
    start_op(5);
    wait_done("t1_done_seen", 200);
    check_eq("t1_latency", 128'(first_req_cyc - start_cyc), 128'(9));
    check_eq("t1_reqs",    128'(req_cnt),  128'(5));
    check_eq("t1_gaps",    128'(gap_cnt),  128'(0));
    check_eq("t1_beats",   128'(beat_cnt), 128'(5));
    check_eq("t1_done_lag", 128'(done_cyc - last_beat_cyc), 128'(1));
    check_eq("t1_sb_left", 128'(sb.size()), 128'(0));
    check_eq("t1_busy_after", 128'(out_busy), 128'(0));
    check_eq("t1_done_after", 128'(out_done), 128'(0));

    // T2: downstream stall exhausts credits
    start_op(20);
    wait_req("t2_first_req", 1, 50);
    step();
    step();
    in_force_ready = 1'b0;
    repeat (9) step();
    check_eq("t2_stall_reqs", 128'(req_cnt), 128'(4));
    check_eq("t2_stall_req",  128'(out_read_data_request), 128'(0));
    check_eq("t2_stall_addr", 128'(out_cache_read_address), 128'(5));
    check_eq("t2_stall_valid", 128'(out_force_valid), 128'(1));
    step();
    in_force_ready = 1'b1;
    wait_done("t2_done_seen", 300);
    check_eq("t2_reqs",  128'(req_cnt),  128'(20));
    check_eq("t2_beats", 128'(beat_cnt), 128'(20));
    check_eq("t2_ovf",   128'(out_overflow_error), 128'(0));
    check_eq("t2_sb_left", 128'(sb.size()), 128'(0));

    // T3: empty cell
    start_op(0);
    check_eq("t3_done", 128'(out_done), 128'(1));
    check_eq("t3_busy", 128'(out_busy), 128'(1));
    check_eq("t3_req",  128'(out_read_data_request), 128'(0));
    step();
    check_eq("t3_done_drop", 128'(out_done), 128'(0));
    check_eq("t3_busy_drop", 128'(out_busy), 128'(0));
    check_eq("t3_done_cnt",  128'(done_cnt), 128'(1));
    check_eq("t3_done_lag",  128'(done_cyc - start_cyc), 128'(1));
    check_eq("t3_reqs",      128'(req_cnt), 128'(0));

    // T4: start while busy must be ignored
    start_op(10);
    wait_req("t4_first_req", 1, 50);
    in_particle_count = CAW'(3);
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    wait_done("t4_done_seen", 300);
    check_eq("t4_reqs",  128'(req_cnt),  128'(10));
    check_eq("t4_beats", 128'(beat_cnt), 128'(10));
    check_eq("t4_sb_left", 128'(sb.size()), 128'(0));

    // T5: reset while draining with two entries queued
    in_force_ready = 1'b0;
    start_op(2);
    wait_req("t5_reqs", 2, 50);
    repeat (3) step();
    check_eq("t5_pre_valid", 128'(out_force_valid), 128'(1));
    check_eq("t5_pre_busy",  128'(out_busy), 128'(1));
    pulse_reset();
    check_eq("t5_post_valid", 128'(out_force_valid), 128'(0));
    check_eq("t5_post_busy",  128'(out_busy), 128'(0));
    check_eq("t5_post_req",   128'(out_read_data_request), 128'(0));
    in_force_ready = 1'b1;
    repeat (10) step();
    check_eq("t5_no_done",  128'(done_cnt), 128'(0));
    check_eq("t5_no_beats", 128'(beat_cnt), 128'(0));
    start_op(3);
    wait_done("t5_restart_done", 200);
    check_eq("t5_restart_beats", 128'(beat_cnt), 128'(3));
    check_eq("t5_sb_left", 128'(sb.size()), 128'(0));

    // T6: injected readouts fill the FIFO, one more overflows
    salt++;
    sb_clear();
    in_force_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inj_valid = 1'b1;
      inj_drop  = (i == 4);
      inj_data  = cache_entry(100 + i, salt);
      step();
    end
    inj_valid = 1'b0;
    inj_drop  = 1'b0;
    check_eq("t6_ovf_set", 128'(out_overflow_error), 128'(1));
    check_eq("t6_valid",   128'(out_force_valid), 128'(1));
    in_force_ready = 1'b1;
    repeat (6) step();
    check_eq("t6_beats",     128'(beat_cnt), 128'(4));
    check_eq("t6_sb_left",   128'(sb.size()), 128'(0));
    check_eq("t6_ovf_stick", 128'(out_overflow_error), 128'(1));
    check_eq("t6_empty",     128'(out_force_valid), 128'(0));
    pulse_reset();
    check_reset_state("t6_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
